// File: rtl/smac_pkg.sv
// Shared definitions for the serial-MAC datapath stages: default geometry,
// derived widths, the feeder FSM state type and a reference popcount.
package smac_pkg;

  localparam int M_LANES = 16;
  localparam int PA_BITS = 8;
  localparam int ACW     = $clog2(M_LANES) + 1;
  localparam int CNTW    = (PA_BITS > 1) ? $clog2(PA_BITS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feed_state_e;

  // Count of set bits in one lane-wide bit-plane
  function automatic logic [ACW-1:0] popcount(input logic [M_LANES-1:0] v);
    logic [ACW-1:0] n;
    n = '0;
    for (int i = 0; i < M_LANES; i++) begin
      n = n + ACW'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ac1_feed_if.sv
// Operand handshake and AC1 link of the bit-serial feeder; master is the
// operand source plus AC1 feedback, slave is the feeder itself.
interface ac1_feed_if #(
  parameter int M  = 16,
  parameter int Pa = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [M*Pa-1:0]        act;
  logic [M-1:0]           wgt;
  logic [$clog2(M)-1:0]   ac1_msb;
  logic [$clog2(M):0]     inr_ac1;
  logic                   w_and_s;
  logic                   cl_en;
  logic                   busy;
  logic                   done;

  modport master (
    output in_valid, act, wgt, ac1_msb,
    input  in_ready, inr_ac1, w_and_s, cl_en, busy, done
  );

  modport slave (
    input  in_valid, act, wgt, ac1_msb,
    output in_ready, inr_ac1, w_and_s, cl_en, busy, done
  );

endinterface

// File: rtl/popcnt_tree.sv
// Purely combinational N-input population count built as a balanced binary
// adder tree; inputs are zero-padded up to the next power of two.
module popcnt_tree #(
  parameter int N = 16,
  parameter int W = $clog2(N) + 1
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  localparam int LV = (N > 1) ? $clog2(N) : 0;
  localparam int NP = 1 << LV;

  for (genvar lv = 0; lv <= LV; lv++) begin : g_lvl
    localparam int CNT = NP >> lv;
    logic [W-1:0] sum [CNT];
    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (lv == 0) begin : g_leaf
        if (j < N) begin : g_in
          assign sum[j] = W'(bits[j]);
        end else begin : g_pad
          assign sum[j] = '0;
        end
      end else begin : g_add
        assign sum[j] = g_lvl[lv-1].sum[2*j] + g_lvl[lv-1].sum[2*j+1];
      end
    end
  end

  assign count = g_lvl[LV].sum[0];

endmodule

// File: rtl/ac1_feed.sv
// Bit-serial operand feeder: streams activation bit-slices LSB first, masks
// them with the weight plane, popcounts and folds in the AC1 feedback.
module ac1_feed
  import smac_pkg::*;
#(
  parameter int M  = M_LANES,
  parameter int Pa = PA_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  ac1_feed_if.slave   bus
);

  localparam int            SUM_W  = $clog2(M) + 1;
  localparam int            K_W    = (Pa > 1) ? $clog2(Pa) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(Pa - 1);

  feed_state_e              state_r;
  logic [K_W-1:0]           k_r;
  logic [M-1:0][Pa-1:0]     act_r;
  logic [M-1:0]             wgt_r;
  logic                     w_and_s_r;
  logic                     cl_en_r;
  logic                     busy_r;
  logic                     done_r;

  logic                     last_s;
  logic [M-1:0]             slice_s;
  logic [SUM_W-1:0]         pop_s;
  logic [SUM_W-1:0]         inr_s;

  // In RUN the source is only offered a slot on the final slice.
  assign last_s       = (k_r == K_LAST);
  assign bus.in_ready = (state_r == IDLE) || last_s;

  // Current bit-slice of every lane, masked by its weight bit
  always_comb begin
    slice_s = '0;
    for (int i = 0; i < M; i++) begin
      slice_s[i] = act_r[i][k_r] & wgt_r[i];
    end
  end

  popcnt_tree #(
    .N (M),
    .W (SUM_W)
  ) u_popcnt (
    .bits  (slice_s),
    .count (pop_s)
  );

  // Partial sum toward AC1; the first slice loads instead of accumulating
  always_comb begin
    inr_s = '0;
    if (!busy_r) begin
      inr_s = '0;
    end else if (cl_en_r) begin
      inr_s = pop_s;
    end else begin
      inr_s = pop_s + SUM_W'(bus.ac1_msb);
    end
  end

  assign bus.inr_ac1 = inr_s;
  assign bus.w_and_s = w_and_s_r;
  assign bus.cl_en   = cl_en_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  // Transaction FSM, slice counter, operand capture and registered controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      k_r       <= '0;
      act_r     <= '0;
      wgt_r     <= '0;
      w_and_s_r <= 1'b0;
      cl_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          k_r    <= '0;
          if (bus.in_valid) begin
            act_r     <= bus.act;
            wgt_r     <= bus.wgt;
            state_r   <= RUN;
            busy_r    <= 1'b1;
            w_and_s_r <= 1'b1;
            cl_en_r   <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
            w_and_s_r <= 1'b0;
            cl_en_r   <= 1'b0;
          end
        end
        RUN: begin
          if (last_s) begin
            done_r <= 1'b1;
            k_r    <= '0;
            // Back-to-back: reload without leaving RUN so no idle slot appears.
            if (bus.in_valid) begin
              act_r   <= bus.act;
              wgt_r   <= bus.wgt;
              cl_en_r <= 1'b1;
            end else begin
              state_r   <= IDLE;
              busy_r    <= 1'b0;
              w_and_s_r <= 1'b0;
              cl_en_r   <= 1'b0;
            end
          end else begin
            done_r  <= 1'b0;
            k_r     <= k_r + K_W'(1);
            cl_en_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          k_r       <= '0;
          w_and_s_r <= 1'b0;
          cl_en_r   <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac1_feed.sv
// Self-checking bench for ac1_feed with an attached AC1 shift-accumulator;
// expectations come from dot products and the S_k = p_k + S_{k-1}/2 rule.
module tb_ac1_feed;

  localparam int M  = 16;
  localparam int PA = 8;
  localparam int MW = $clog2(M);
  localparam int AW = MW + PA;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ac1_feed_if #(.M(M), .Pa(PA)) bus ();

  ac1_feed #(.M(M), .Pa(PA)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // AC1 shift-accumulator: load/accumulate at the top, shift finished bits down
  logic [AW-1:0] ac1_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac1_r <= '0;
    end else if (bus.w_and_s) begin
      if (bus.cl_en) ac1_r <= {bus.inr_ac1, {(PA-1){1'b0}}};
      else           ac1_r <= {bus.inr_ac1, ac1_r[PA-1:1]};
    end
  end
  assign bus.ac1_msb = ac1_r[AW-1:PA];

  int n_vec = 0;
  int n_err = 0;
  int obs_inr [PA];

  typedef struct {
    logic [M*PA-1:0] a;
    logic [M-1:0]    w;
    int              exp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int dot(input logic [M*PA-1:0] a, input logic [M-1:0] w);
    int s = 0;
    for (int i = 0; i < M; i++) s += w[i] ? int'(a[i*PA +: PA]) : 0;
    return s;
  endfunction

  function automatic int slice_pop(input logic [M*PA-1:0] a, input logic [M-1:0] w, input int k);
    int s = 0;
    for (int i = 0; i < M; i++) if (a[i*PA + k] && w[i]) s++;
    return s;
  endfunction

  function automatic logic [M*PA-1:0] rnd_act();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer an operand set at the current negedge; block must be idle
  task automatic offer(input logic [M*PA-1:0] a, input logic [M-1:0] w);
    bus.in_valid = 1'b1;
    bus.act      = a;
    bus.wgt      = w;
    chk("in_ready_idle", bus.in_ready, 1'b1);
  endtask

  // Check the Pa RUN cycles of one accepted transaction
  task automatic body(input logic [M*PA-1:0] a, input logic [M-1:0] w,
                      input bit prev_done, input int prev_exp,
                      input bit chain, input logic [M*PA-1:0] na, input logic [M-1:0] nw);
    int s = 0;
    int e;
    e = dot(a, w);
    for (int k = 0; k < PA; k++) begin
      @(negedge clk);
      s = (k == 0) ? slice_pop(a, w, k) : slice_pop(a, w, k) + s / 2;
      obs_inr[k] = int'(bus.inr_ac1);
      chk("inr_ac1", bus.inr_ac1, s);
      chk("cl_en", bus.cl_en, (k == 0));
      chk("w_and_s", bus.w_and_s, 1'b1);
      chk("busy", bus.busy, 1'b1);
      chk("done_run", bus.done, (k == 0 && prev_done));
      chk("in_ready_run", bus.in_ready, (k == PA - 1));
      if (k == 0 && prev_done) chk("ac1_prev", ac1_r, prev_exp);
      if (k == 0) begin
        if (chain) begin
          bus.act = na;
          bus.wgt = nw;
        end else begin
          bus.in_valid = 1'b0;
          bus.act      = rnd_act();
          bus.wgt      = 16'($urandom);
        end
      end
    end
    if (!chain) begin
      @(negedge clk);
      chk("done", bus.done, 1'b1);
      chk("ac1_final", ac1_r, e);
      chk("busy_after", bus.busy, 1'b0);
      chk("w_and_s_after", bus.w_and_s, 1'b0);
      chk("inr_after", bus.inr_ac1, 0);
      chk("in_ready_after", bus.in_ready, 1'b1);
    end
  endtask

  initial begin
    int seq_ones [PA];
    logic [M*PA-1:0] a3 [3];
    logic [M-1:0]    w3 [3];
    logic [AW-1:0]   held;
    seq_ones = '{16, 24, 28, 30, 31, 31, 31, 31};

    tbl[0] = '{{(M*PA){1'b1}}, 16'hFFFF, 4080};
    tbl[1] = '{rnd_act(), 16'h0000, 0};
    tbl[2] = '{128'hA5 << (3 * PA), 16'h0008, 165};
    tbl[3] = '{{16{8'h01}}, 16'hFFFF, 16};
    tbl[4] = '{{16{8'h80}}, 16'h00FF, 1024};
    tbl[5] = '{128'hFF << (15 * PA), 16'h8000, 255};

    bus.in_valid = 1'b0;
    bus.act      = '0;
    bus.wgt      = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_w_and_s", bus.w_and_s, 1'b0);
    chk("rst_cl_en", bus.cl_en, 1'b0);
    chk("rst_inr", bus.inr_ac1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Table-driven directed transactions
    for (int j = 0; j < 6; j++) begin
      offer(tbl[j].a, tbl[j].w);
      body(tbl[j].a, tbl[j].w, 1'b0, 0, 1'b0, '0, '0);
      chk("ac1_table", ac1_r, tbl[j].exp);
      if (j == 0) for (int k = 0; k < PA; k++) chk("inr_seq_ones", obs_inr[k], seq_ones[k]);
      if (j == 1) for (int k = 0; k < PA; k++) chk("inr_wgt0", obs_inr[k], 0);
    end

    // Back-to-back: three transactions with in_valid held
    for (int t = 0; t < 3; t++) begin
      a3[t] = rnd_act();
      w3[t] = 16'($urandom);
    end
    offer(a3[0], w3[0]);
    body(a3[0], w3[0], 1'b0, 0, 1'b1, a3[1], w3[1]);
    body(a3[1], w3[1], 1'b1, dot(a3[0], w3[0]), 1'b1, a3[2], w3[2]);
    body(a3[2], w3[2], 1'b1, dot(a3[1], w3[1]), 1'b0, '0, '0);

    // Stalled source: AC1 must hold while idle, next start loads
    held = ac1_r;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_w_and_s", bus.w_and_s, 1'b0);
      chk("stall_ac1", ac1_r, held);
      chk("stall_done", bus.done, 1'b0);
      chk("stall_in_ready", bus.in_ready, 1'b1);
    end
    a3[0] = rnd_act();
    w3[0] = 16'($urandom);
    offer(a3[0], w3[0]);
    body(a3[0], w3[0], 1'b0, 0, 1'b0, '0, '0);

    // Randomized transactions with random idle gaps
    for (int t = 0; t < 10; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a3[0] = rnd_act();
      w3[0] = 16'($urandom);
      offer(a3[0], w3[0]);
      body(a3[0], w3[0], 1'b0, 0, 1'b0, '0, '0);
    end

    // Reset mid-RUN: immediate abort, no done afterwards
    offer(tbl[0].a, tbl[0].w);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_w_and_s", bus.w_and_s, 1'b0);
    chk("abort_cl_en", bus.cl_en, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_inr", bus.inr_ac1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_no_done", bus.done, 1'b0);
      chk("abort_in_ready", bus.in_ready, 1'b1);
      chk("abort_idle", bus.busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
